// File: rtl/video_register_sink_pkg.sv
// Shared register map and write-transaction type for the video register sink.
package video_regs_pkg;

  localparam int CLUT_AW = 8;
  localparam int DATA_W  = 24;
  localparam int ADR_W   = 7;

  localparam logic [ADR_W-1:0] REG_CLUT_BASE   = 7'h00;
  localparam logic [ADR_W-1:0] REG_ICM         = 7'h40;
  localparam logic [ADR_W-1:0] REG_TRANSP      = 7'h41;
  localparam logic [ADR_W-1:0] REG_PLANE_ORDER = 7'h42;
  localparam logic [ADR_W-1:0] REG_CLUT_BANK   = 7'h43;
  localparam logic [ADR_W-1:0] REG_TRANS_A     = 7'h44;
  localparam logic [ADR_W-1:0] REG_TRANS_B     = 7'h46;
  localparam logic [ADR_W-1:0] REG_BACKDROP    = 7'h58;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
    logic              valid;
  } reg_write_s;

endpackage

// File: rtl/video_register_sink_if.sv
// Bundles the two control-unit write streams and the decoded display outputs.
interface video_register_sink_if;
  import video_regs_pkg::*;

  logic [ADR_W-1:0]   ch0_adr;
  logic [DATA_W-1:0]  ch0_data;
  logic               ch0_write;
  logic [ADR_W-1:0]   ch1_adr;
  logic [DATA_W-1:0]  ch1_data;
  logic               ch1_write;

  logic               clut_we;
  logic [CLUT_AW-1:0] clut_adr;
  logic [DATA_W-1:0]  clut_data;
  logic [3:0]         icm_a;
  logic [3:0]         icm_b;
  logic               plane_order;
  logic [DATA_W-1:0]  transp_ctrl;
  logic [DATA_W-1:0]  trans_color_a;
  logic [DATA_W-1:0]  trans_color_b;
  logic [3:0]         backdrop;
  logic               overflow;

  modport master (
    output ch0_adr, ch0_data, ch0_write, ch1_adr, ch1_data, ch1_write,
    input  clut_we, clut_adr, clut_data, icm_a, icm_b, plane_order,
           transp_ctrl, trans_color_a, trans_color_b, backdrop, overflow
  );

  modport slave (
    input  ch0_adr, ch0_data, ch0_write, ch1_adr, ch1_data, ch1_write,
    output clut_we, clut_adr, clut_data, icm_a, icm_b, plane_order,
           transp_ctrl, trans_color_a, trans_color_b, backdrop, overflow
  );

endinterface

// File: rtl/video_register_sink_arbiter.sv
// Merges two register-write streams into one grant per cycle using a one-entry
// pending slot per channel and a round-robin pointer that flips only on conflicts.
module reg_write_arbiter
  import video_regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  reg_write_s i_ch0,
  input  reg_write_s i_ch1,
  output reg_write_s o_grant,
  output logic       o_overflow
);

  reg_write_s r_slot [2];
  logic       r_rrPtr;
  logic       r_overflow;

  reg_write_s w_live [2];
  reg_write_s w_cand [2];
  logic [1:0] w_grant;
  logic [1:0] w_drop;
  logic       w_conflict;

  // A held slot always outranks the live strobe of its own channel.
  always_comb begin
    w_live[0]  = i_ch0;
    w_live[1]  = i_ch1;
    for (int c = 0; c < 2; c++) begin
      w_cand[c] = r_slot[c].valid ? r_slot[c] : w_live[c];
    end
    w_conflict = w_cand[0].valid && w_cand[1].valid;
    w_grant[0] = w_cand[0].valid && (!w_cand[1].valid || !r_rrPtr);
    w_grant[1] = w_cand[1].valid && (!w_cand[0].valid || r_rrPtr);
    for (int c = 0; c < 2; c++) begin
      w_drop[c] = r_slot[c].valid && !w_grant[c] && w_live[c].valid;
    end
    o_grant = w_grant[1] ? w_cand[1] : w_cand[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot[0]  <= '0;
      r_slot[1]  <= '0;
      r_rrPtr    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        // A granted slot is refilled by a same-cycle strobe so nothing is lost.
        if (w_grant[c]) begin
          r_slot[c] <= r_slot[c].valid ? w_live[c] : '0;
        end else if (!r_slot[c].valid) begin
          r_slot[c] <= w_live[c];
        end
      end
      if (w_conflict) r_rrPtr <= ~r_rrPtr;
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;

endmodule

// File: rtl/video_register_sink.sv
// Decodes arbitrated control-unit writes into CLUT RAM writes and held
// display-control registers for the pixel pipeline.
module video_register_sink
  import video_regs_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  video_register_sink_if.slave bus
);

  reg_write_s w_ch0;
  reg_write_s w_ch1;
  reg_write_s w_grant;
  logic       w_overflow;

  logic               r_clutWe;
  logic [CLUT_AW-1:0] r_clutAdr;
  logic [DATA_W-1:0]  r_clutData;
  logic [1:0]         r_clutBank;
  logic [3:0]         r_icmA;
  logic [3:0]         r_icmB;
  logic               r_planeOrder;
  logic [DATA_W-1:0]  r_transpCtrl;
  logic [DATA_W-1:0]  r_transA;
  logic [DATA_W-1:0]  r_transB;
  logic [3:0]         r_backdrop;

  assign w_ch0 = '{adr: bus.ch0_adr, data: bus.ch0_data, valid: bus.ch0_write};
  assign w_ch1 = '{adr: bus.ch1_adr, data: bus.ch1_data, valid: bus.ch1_write};

  reg_write_arbiter u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .i_ch0      (w_ch0),
    .i_ch1      (w_ch1),
    .o_grant    (w_grant),
    .o_overflow (w_overflow)
  );

  // Addresses below 0x40 are colour entries in the currently selected bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clutWe     <= 1'b0;
      r_clutAdr    <= '0;
      r_clutData   <= '0;
      r_clutBank   <= '0;
      r_icmA       <= '0;
      r_icmB       <= '0;
      r_planeOrder <= 1'b0;
      r_transpCtrl <= '0;
      r_transA     <= '0;
      r_transB     <= '0;
      r_backdrop   <= '0;
    end else begin
      r_clutWe <= 1'b0;
      if (w_grant.valid) begin
        if (w_grant.adr[6] == 1'b0) begin
          r_clutWe   <= 1'b1;
          r_clutAdr  <= {r_clutBank, w_grant.adr[5:0]};
          r_clutData <= w_grant.data;
        end else begin
          case (w_grant.adr)
            REG_ICM: begin
              r_icmA <= w_grant.data[3:0];
              r_icmB <= w_grant.data[11:8];
            end
            REG_TRANSP:      r_transpCtrl <= w_grant.data;
            REG_PLANE_ORDER: r_planeOrder <= w_grant.data[0];
            REG_CLUT_BANK:   r_clutBank   <= w_grant.data[1:0];
            REG_TRANS_A:     r_transA     <= w_grant.data;
            REG_TRANS_B:     r_transB     <= w_grant.data;
            REG_BACKDROP:    r_backdrop   <= w_grant.data[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.clut_we       = r_clutWe;
  assign bus.clut_adr      = r_clutAdr;
  assign bus.clut_data     = r_clutData;
  assign bus.icm_a         = r_icmA;
  assign bus.icm_b         = r_icmB;
  assign bus.plane_order   = r_planeOrder;
  assign bus.transp_ctrl   = r_transpCtrl;
  assign bus.trans_color_a = r_transA;
  assign bus.trans_color_b = r_transB;
  assign bus.backdrop      = r_backdrop;
  assign bus.overflow      = w_overflow;

endmodule

// File: tb/tb_video_register_sink.sv
// Scoreboard bench: each driven cycle queues the expected output snapshot for the
// following clock edge, which is popped and compared one cycle later.
module tb_video_register_sink;
  import video_regs_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  video_register_sink_if bus ();

  video_register_sink dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        clutWe;
    logic [7:0]  clutAdr;
    logic [23:0] clutData;
    logic [3:0]  icmA;
    logic [3:0]  icmB;
    logic        planeOrder;
    logic [23:0] transpCtrl;
    logic [23:0] transA;
    logic [23:0] transB;
    logic [3:0]  backdrop;
    logic        overflow;
  } outSnap_t;

  outSnap_t expState;
  outSnap_t scoreboard [$];
  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    outSnap_t e;
    if (scoreboard.size() == 0) return;
    e = scoreboard.pop_front();
    checkValue("clut_we", 32'(bus.clut_we), 32'(e.clutWe));
    if (e.clutWe) begin
      checkValue("clut_adr", 32'(bus.clut_adr), 32'(e.clutAdr));
      checkValue("clut_data", 32'(bus.clut_data), 32'(e.clutData));
    end
    checkValue("icm_a", 32'(bus.icm_a), 32'(e.icmA));
    checkValue("icm_b", 32'(bus.icm_b), 32'(e.icmB));
    checkValue("plane_order", 32'(bus.plane_order), 32'(e.planeOrder));
    checkValue("transp_ctrl", 32'(bus.transp_ctrl), 32'(e.transpCtrl));
    checkValue("trans_color_a", 32'(bus.trans_color_a), 32'(e.transA));
    checkValue("trans_color_b", 32'(bus.trans_color_b), 32'(e.transB));
    checkValue("backdrop", 32'(bus.backdrop), 32'(e.backdrop));
    checkValue("overflow", 32'(bus.overflow), 32'(e.overflow));
  endtask

  task automatic driveInputs(input logic w0, input logic [6:0] a0, input logic [23:0] d0,
                             input logic w1, input logic [6:0] a1, input logic [23:0] d1);
    bus.ch0_write = w0;
    bus.ch0_adr   = a0;
    bus.ch0_data  = d0;
    bus.ch1_write = w1;
    bus.ch1_adr   = a1;
    bus.ch1_data  = d1;
  endtask

  // expState must already describe the outputs expected after this cycle's edge.
  task automatic applyStimulus(input logic w0, input logic [6:0] a0, input logic [23:0] d0,
                               input logic w1, input logic [6:0] a1, input logic [23:0] d1);
    @(negedge clk);
    checkOutput();
    reset = 1'b0;
    driveInputs(w0, a0, d0, w1, a1, d1);
    scoreboard.push_back(expState);
    expState.clutWe = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);
  endtask

  task automatic doReset(input logic w0, input logic [6:0] a0, input logic [23:0] d0,
                         input logic w1, input logic [6:0] a1, input logic [23:0] d1);
    @(negedge clk);
    checkOutput();
    reset = 1'b1;
    driveInputs(w0, a0, d0, w1, a1, d1);
    expState = '0;
    scoreboard.push_back(expState);
  endtask

  initial begin
    expState = '0;
    driveInputs(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);

    // Bank select then colour write lands in bank 2, one-cycle pulse.
    doReset(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);
    applyStimulus(1'b1, 7'h43, 24'h000002, 1'b0, 7'h00, 24'h0);
    expState.clutWe   = 1'b1;
    expState.clutAdr  = 8'h85;
    expState.clutData = 24'hFF8000;
    applyStimulus(1'b1, 7'h05, 24'hFF8000, 1'b0, 7'h00, 24'h0);
    idleCycle();
    idleCycle();

    // Single conflict: ch0 wins at N+1, ch1 lands at N+2.
    doReset(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);
    expState.icmA = 4'h3;
    expState.icmB = 4'hB;
    applyStimulus(1'b1, 7'h40, 24'h000B03, 1'b1, 7'h44, 24'h123456);
    expState.transA = 24'h123456;
    idleCycle();
    idleCycle();

    // Three back-to-back conflicts: grants ch0, ch1, ch0; ch1's third write is dropped.
    doReset(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);
    expState.transpCtrl = 24'h0000A1;
    applyStimulus(1'b1, 7'h41, 24'h0000A1, 1'b1, 7'h58, 24'h000001);
    expState.backdrop = 4'h1;
    applyStimulus(1'b1, 7'h41, 24'h0000A2, 1'b1, 7'h58, 24'h000002);
    expState.transpCtrl = 24'h0000A2;
    expState.overflow   = 1'b1;
    applyStimulus(1'b1, 7'h41, 24'h0000A3, 1'b1, 7'h58, 24'h000003);
    expState.backdrop = 4'h2;
    idleCycle();
    expState.transpCtrl = 24'h0000A3;
    idleCycle();
    idleCycle();
    idleCycle();

    // Plane order from ch1 alone, repeated write, then an unmapped address.
    doReset(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);
    expState.planeOrder = 1'b1;
    applyStimulus(1'b0, 7'h00, 24'h0, 1'b1, 7'h42, 24'h000001);
    applyStimulus(1'b0, 7'h00, 24'h0, 1'b1, 7'h42, 24'h000001);
    applyStimulus(1'b1, 7'h7F, 24'hFFFFFF, 1'b0, 7'h00, 24'h0);
    applyStimulus(1'b0, 7'h00, 24'h0, 1'b1, 7'h7F, 24'hFFFFFF);
    idleCycle();

    // Reset with ch1 pending and overflow set: pending write must never appear.
    doReset(1'b0, 7'h00, 24'h0, 1'b0, 7'h00, 24'h0);
    expState.backdrop = 4'h5;
    applyStimulus(1'b1, 7'h58, 24'h000005, 1'b1, 7'h44, 24'hABCDEF);
    expState.transA = 24'hABCDEF;
    applyStimulus(1'b1, 7'h40, 24'h000102, 1'b1, 7'h46, 24'h654321);
    expState.icmA     = 4'h2;
    expState.icmB     = 4'h1;
    expState.overflow = 1'b1;
    applyStimulus(1'b0, 7'h00, 24'h0, 1'b1, 7'h41, 24'h111111);
    doReset(1'b1, 7'h41, 24'h777777, 1'b1, 7'h02, 24'h333333);
    idleCycle();
    idleCycle();
    idleCycle();

    @(negedge clk);
    checkOutput();
    if (scoreboard.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", scoreboard.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
